// File: rtl/perif_temporizador_if.sv
// CPU-port side bundle of the peripheral timer: configuration in, status/count/interrupt out.
interface perif_temporizador_if;
  logic [7:0] cfg_periodo;
  logic [7:0] cfg_ctrl;
  logic       evento;
  logic       interrupcion;
  logic [7:0] estado;
  logic [7:0] cuenta;

  // CPU side: drives configuration and the external event, reads status
  modport master (
    output cfg_periodo,
    output cfg_ctrl,
    output evento,
    input  interrupcion,
    input  estado,
    input  cuenta
  );

  // Peripheral side: consumes configuration, produces status
  modport slave (
    input  cfg_periodo,
    input  cfg_ctrl,
    input  evento,
    output interrupcion,
    output estado,
    output cuenta
  );
endinterface

// File: rtl/perif_temporizador.sv
// Peripheral timer and interrupt source. Prescaled down-counter with periodic or
// one-shot expiry, plus a synchronized external event edge detector. Both raise
// sticky pending flags (with overrun) that the CPU clears via a rising ack bit.
// PRESC is the number of clock cycles per timer tick; legal range is 1..256.
module perif_temporizador #(
  parameter int unsigned PRESC = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  perif_temporizador_if.slave  bus
);

  localparam int unsigned CW        = 8;
  localparam int unsigned PW        = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC - 1);

  localparam int unsigned B_EN_TMR   = 0;
  localparam int unsigned B_EN_EXT   = 1;
  localparam int unsigned B_ACK      = 2;
  localparam int unsigned B_ONE_SHOT = 3;

  // Control decode
  logic          en_tmr;
  logic          en_ext;
  logic          ack;
  logic          one_shot;
  logic [2:0]    ctrl_q;
  logic          en_tmr_rise;
  logic          ack_rise;

  // Timer state
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          tick;
  logic          tmr_set;

  // External event path
  logic          s1_q;
  logic          s2_q;
  logic          s3_q;
  logic          ext_rise;
  logic          ext_set;

  // Interrupt flags
  logic          pend_tmr_q;
  logic          pend_tmr_d;
  logic          pend_ext_q;
  logic          pend_ext_d;
  logic          ovr_tmr_q;
  logic          ovr_tmr_d;
  logic          ovr_ext_q;
  logic          ovr_ext_d;

  // Upper control bits and the en_ext history bit carry no function
  logic          unused_ok;
  assign unused_ok = ^{bus.cfg_ctrl[7:4], ctrl_q[B_EN_EXT]};

  assign en_tmr   = bus.cfg_ctrl[B_EN_TMR];
  assign en_ext   = bus.cfg_ctrl[B_EN_EXT];
  assign ack      = bus.cfg_ctrl[B_ACK];
  assign one_shot = bus.cfg_ctrl[B_ONE_SHOT];

  assign en_tmr_rise = en_tmr & ~ctrl_q[B_EN_TMR];
  assign ack_rise    = ack & ~ctrl_q[B_ACK];

  assign tick     = (presc_q == PRESC_MAX);
  assign ext_rise = s2_q & ~s3_q;
  assign ext_set  = ext_rise & en_ext;

  // Previous-cycle copy of the control bits used for rise detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= 3'b000;
    end else begin
      ctrl_q <= bus.cfg_ctrl[2:0];
    end
  end

  // Next counter/prescaler value and expiry strobe
  always_comb begin
    cnt_d   = cnt_q;
    presc_d = presc_q;
    tmr_set = 1'b0;
    if (en_tmr_rise) begin
      // Enable rise always restarts from a fresh period and prescaler phase
      cnt_d   = bus.cfg_periodo;
      presc_d = '0;
    end else if (!en_tmr || (cnt_q == '0)) begin
      // Paused or idle: count holds, prescaler phase is discarded
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
      if (cnt_q == CW'(1)) begin
        tmr_set = 1'b1;
        cnt_d   = one_shot ? '0 : bus.cfg_periodo;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Counter and prescaler registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      presc_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
    end
  end

  // Two-flop synchronizer for evento plus a history flop for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.evento;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Flag update: a set on the ack edge keeps the pending flag but drops the overrun
  always_comb begin
    pend_tmr_d = pend_tmr_q;
    pend_ext_d = pend_ext_q;
    ovr_tmr_d  = ovr_tmr_q;
    ovr_ext_d  = ovr_ext_q;

    if (ack_rise) begin
      pend_tmr_d = 1'b0;
      pend_ext_d = 1'b0;
      ovr_tmr_d  = 1'b0;
      ovr_ext_d  = 1'b0;
    end

    if (tmr_set) begin
      pend_tmr_d = 1'b1;
      if (pend_tmr_q && !ack_rise) begin
        ovr_tmr_d = 1'b1;
      end
    end

    if (ext_set) begin
      pend_ext_d = 1'b1;
      if (pend_ext_q && !ack_rise) begin
        ovr_ext_d = 1'b1;
      end
    end
  end

  // Pending and overrun flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_tmr_q <= 1'b0;
      pend_ext_q <= 1'b0;
      ovr_tmr_q  <= 1'b0;
      ovr_ext_q  <= 1'b0;
    end else begin
      pend_tmr_q <= pend_tmr_d;
      pend_ext_q <= pend_ext_d;
      ovr_tmr_q  <= ovr_tmr_d;
      ovr_ext_q  <= ovr_ext_d;
    end
  end

  // Status outputs are direct views of flop state; the interrupt is an OR of flops
  assign bus.interrupcion = pend_tmr_q | pend_ext_q;
  assign bus.estado       = {4'b0000, ovr_ext_q, ovr_tmr_q, pend_ext_q, pend_tmr_q};
  assign bus.cuenta       = cnt_q;

endmodule

// File: tb/tb_perif_temporizador.sv
// Bench for perif_temporizador: directed vector table, hand-written corner
// sequences, and randomized traffic checked every cycle against a timestamp model.
module tb_perif_temporizador;

  localparam int unsigned PRESC = 4;
  localparam int          PR    = int'(PRESC);

  logic clk   = 1'b0;
  logic reset = 1'b0;

  perif_temporizador_if bus ();

  perif_temporizador #(.PRESC(PRESC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit mdl_on = 1'b0;

  typedef struct {
    logic [7:0] ctrl;
    logic [7:0] per;
    logic       ev;
    int         n;
    logic [7:0] cnt;
    logic [7:0] est;
    logic       irq;
  } vec_t;

  vec_t vecs[$];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] cnt, input logic [7:0] est,
                           input logic irq);
    check({name, ".cuenta"}, bus.cuenta, cnt);
    check({name, ".estado"}, bus.estado, est);
    check({name, ".irq"}, 8'(bus.interrupcion), 8'(irq));
  endtask

  task automatic clear_flags();
    bus.cfg_ctrl = 8'h04;
    step(1);
    bus.cfg_ctrl = 8'h00;
    step(1);
  endtask

  // Reference model: ticks fall at load_edge + k*PRESC; expiry when k reaches the period
  int       n_edge = 0;
  bit       m_pen = 1'b0, m_pack = 1'b0;
  int       m_cnt = 0, m_st = 0, m_len = 0;
  bit       m_pt = 1'b0, m_pe = 1'b0, m_ot = 1'b0, m_oe = 1'b0;
  bit [2:0] m_ev = 3'b000;

  task automatic mdl_reset();
    n_edge = 0; m_pen = 1'b0; m_pack = 1'b0;
    m_cnt = 0; m_st = 0; m_len = 0;
    m_pt = 1'b0; m_pe = 1'b0; m_ot = 1'b0; m_oe = 1'b0;
    m_ev = 3'b000;
  endtask

  task automatic mdl_edge();
    bit en, ext, ack, os, tset, eset, ackr;
    int el, rem;
    n_edge++;
    en   = bus.cfg_ctrl[0];
    ext  = bus.cfg_ctrl[1];
    ack  = bus.cfg_ctrl[2];
    os   = bus.cfg_ctrl[3];
    ackr = ack && !m_pack;
    tset = 1'b0;
    if (en && !m_pen) begin
      m_st  = n_edge;
      m_len = int'(bus.cfg_periodo);
      m_cnt = m_len;
    end else if (en && m_cnt != 0) begin
      el = n_edge - m_st;
      if (el % PR == 0) begin
        rem = m_len - el / PR;
        if (rem <= 0) begin
          tset  = 1'b1;
          m_st  = n_edge;
          m_len = os ? 0 : int'(bus.cfg_periodo);
          m_cnt = m_len;
        end else begin
          m_cnt = rem;
        end
      end
    end
    // evento sampled at edge n is seen as a rise at edge n+2
    eset = ext && m_ev[1] && !m_ev[2];
    m_ev = {m_ev[1:0], bus.evento};
    if (tset) begin
      m_ot = ackr ? 1'b0 : (m_ot | m_pt);
      m_pt = 1'b1;
    end else if (ackr) begin
      m_pt = 1'b0; m_ot = 1'b0;
    end
    if (eset) begin
      m_oe = ackr ? 1'b0 : (m_oe | m_pe);
      m_pe = 1'b1;
    end else if (ackr) begin
      m_pe = 1'b0; m_oe = 1'b0;
    end
    m_pen  = en;
    m_pack = ack;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) mdl_reset();
      else mdl_edge();
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (mdl_on) begin
        check("model.cuenta", bus.cuenta, 8'(m_cnt));
        check("model.estado", bus.estado, {4'b0000, m_oe, m_ot, m_pe, m_pt});
        check("model.irq", 8'(bus.interrupcion), 8'(m_pt | m_pe));
      end
    end
  end

  initial begin
    bus.cfg_ctrl    = 8'h00;
    bus.cfg_periodo = 8'd0;
    bus.evento      = 1'b0;
    reset           = 1'b0;
    step(3);
    mdl_on = 1'b1;
    check_out("reset", 8'd0, 8'h00, 1'b0);
    reset = 1'b1;

    //              ctrl   per   ev   n   cnt  est    irq
    vecs.push_back('{8'h00, 8'd3, 1'b0, 2,  8'd0, 8'h00, 1'b0});
    vecs.push_back('{8'h01, 8'd3, 1'b0, 1,  8'd3, 8'h00, 1'b0}); // E0
    vecs.push_back('{8'h01, 8'd3, 1'b0, 4,  8'd2, 8'h00, 1'b0}); // E0+4
    vecs.push_back('{8'h01, 8'd3, 1'b0, 4,  8'd1, 8'h00, 1'b0}); // E0+8
    vecs.push_back('{8'h01, 8'd3, 1'b0, 3,  8'd1, 8'h00, 1'b0});
    vecs.push_back('{8'h01, 8'd3, 1'b0, 1,  8'd3, 8'h01, 1'b1}); // E0+12
    vecs.push_back('{8'h01, 8'd3, 1'b0, 12, 8'd3, 8'h05, 1'b1}); // E0+24
    vecs.push_back('{8'h05, 8'd3, 1'b0, 1,  8'd3, 8'h00, 1'b0}); // ack
    vecs.push_back('{8'h01, 8'd3, 1'b0, 3,  8'd2, 8'h00, 1'b0});
    vecs.push_back('{8'h00, 8'd3, 1'b0, 10, 8'd2, 8'h00, 1'b0}); // paused
    vecs.push_back('{8'h09, 8'd2, 1'b0, 1,  8'd2, 8'h00, 1'b0}); // one-shot E0
    vecs.push_back('{8'h09, 8'd2, 1'b0, 8,  8'd0, 8'h01, 1'b1});
    vecs.push_back('{8'h09, 8'd2, 1'b0, 40, 8'd0, 8'h01, 1'b1});
    vecs.push_back('{8'h0D, 8'd2, 1'b0, 1,  8'd0, 8'h00, 1'b0});
    vecs.push_back('{8'h08, 8'd2, 1'b0, 1,  8'd0, 8'h00, 1'b0});
    vecs.push_back('{8'h09, 8'd2, 1'b0, 1,  8'd2, 8'h00, 1'b0}); // re-arm
    vecs.push_back('{8'h09, 8'd2, 1'b0, 7,  8'd1, 8'h00, 1'b0});
    vecs.push_back('{8'h09, 8'd2, 1'b0, 1,  8'd0, 8'h01, 1'b1});
    vecs.push_back('{8'h0D, 8'd2, 1'b0, 1,  8'd0, 8'h00, 1'b0});
    vecs.push_back('{8'h02, 8'd2, 1'b0, 3,  8'd0, 8'h00, 1'b0}); // external
    vecs.push_back('{8'h02, 8'd2, 1'b1, 1,  8'd0, 8'h00, 1'b0}); // edge N
    vecs.push_back('{8'h02, 8'd2, 1'b1, 1,  8'd0, 8'h00, 1'b0}); // N+1
    vecs.push_back('{8'h02, 8'd2, 1'b1, 1,  8'd0, 8'h02, 1'b1}); // N+2
    vecs.push_back('{8'h02, 8'd2, 1'b0, 3,  8'd0, 8'h02, 1'b1});
    vecs.push_back('{8'h02, 8'd2, 1'b1, 3,  8'd0, 8'h0A, 1'b1}); // overrun
    vecs.push_back('{8'h06, 8'd2, 1'b1, 1,  8'd0, 8'h00, 1'b0});
    vecs.push_back('{8'h00, 8'd2, 1'b0, 3,  8'd0, 8'h00, 1'b0});
    vecs.push_back('{8'h00, 8'd2, 1'b1, 4,  8'd0, 8'h00, 1'b0}); // dropped
    vecs.push_back('{8'h02, 8'd2, 1'b1, 4,  8'd0, 8'h00, 1'b0}); // level, no edge
    vecs.push_back('{8'h02, 8'd2, 1'b0, 4,  8'd0, 8'h00, 1'b0});
    vecs.push_back('{8'h00, 8'd3, 1'b0, 1,  8'd0, 8'h00, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      bus.cfg_ctrl    = vecs[i].ctrl;
      bus.cfg_periodo = vecs[i].per;
      bus.evento      = vecs[i].ev;
      step(vecs[i].n);
      check_out($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].est, vecs[i].irq);
    end

    // Ack rise landing on the same edge as an expiry with pend and ovr already set
    clear_flags();
    bus.cfg_periodo = 8'd2;
    bus.cfg_ctrl    = 8'h01;
    step(1);
    step(16);
    check_out("coll_pre", 8'd2, 8'h05, 1'b1);
    step(7);
    bus.cfg_ctrl = 8'h05;
    step(1);
    check_out("coll", 8'd2, 8'h01, 1'b1);
    bus.cfg_ctrl = 8'h01;
    step(1);
    clear_flags();

    // Period change mid-count only applies at reload
    bus.cfg_periodo = 8'd3;
    bus.cfg_ctrl    = 8'h01;
    step(1);
    check_out("pchg_e0", 8'd3, 8'h00, 1'b0);
    step(4);
    bus.cfg_periodo = 8'd6;
    step(8);
    check_out("pchg_exp1", 8'd6, 8'h01, 1'b1);
    step(23);
    check_out("pchg_pre2", 8'd1, 8'h01, 1'b1);
    step(1);
    check_out("pchg_exp2", 8'd6, 8'h05, 1'b1);
    clear_flags();

    // Zero period never expires
    bus.cfg_periodo = 8'd0;
    bus.cfg_ctrl    = 8'h01;
    step(2000);
    check_out("per0", 8'd0, 8'h00, 1'b0);
    bus.cfg_ctrl = 8'h00;
    step(1);

    // Reset mid-count acts at once and leaves the timer idle until a new enable rise
    bus.cfg_periodo = 8'd5;
    bus.cfg_ctrl    = 8'h01;
    step(1);
    step(7);
    check_out("rst_pre", 8'd4, 8'h00, 1'b0);
    reset = 1'b0;
    #1;
    check_out("rst_now", 8'd0, 8'h00, 1'b0);
    bus.cfg_ctrl = 8'h00;
    step(2);
    reset = 1'b1;
    step(40);
    check_out("rst_idle", 8'd0, 8'h00, 1'b0);
    bus.cfg_ctrl = 8'h01;
    step(1);
    check_out("rst_e0", 8'd5, 8'h00, 1'b0);
    step(19);
    check_out("rst_pre_exp", 8'd1, 8'h00, 1'b0);
    step(1);
    check_out("rst_exp", 8'd5, 8'h01, 1'b1);
    clear_flags();

    // Randomized traffic; the per-cycle model check covers it
    for (int c = 0; c < 4000; c++) begin
      logic [7:0] ctl;
      ctl = bus.cfg_ctrl;
      if ($urandom_range(0, 11) == 0) ctl[$urandom_range(0, 3)] = ~ctl[$urandom_range(0, 3)];
      if ($urandom_range(0, 9) == 0) ctl[2] = ~ctl[2];
      ctl[7:4] = 4'($urandom);
      bus.cfg_ctrl = ctl;
      if ($urandom_range(0, 19) == 0) bus.cfg_periodo = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 2) == 0) bus.evento = ~bus.evento;
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/perif_temporizador.md
# perif_temporizador

Peripheral timer and interrupt source that sits on the far side of the CPU's port interface. It is configured through two CPU output ports, drives the CPU `interrupcion` line, and returns status and count on two CPU input ports. It raises a level interrupt on timer expiry or on an external event edge, and holds it until the CPU acknowledges through a control bit.

## Interface
- `PRESC`, default 4: clock cycles per timer tick. Legal range is 1..256.
- `clk`  in  1: single clock; all state is on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `cfg_periodo`  in  8: timer period in ticks. Driven by CPU port `s`.
- `cfg_ctrl`  in  8: control, driven by CPU port `s1`.
  - bit0 `en_tmr`
  - bit1 `en_ext`
  - bit2 `ack`
  - bit3 `one_shot`
  - bits 7:4 ignored
- `evento`  in  1: asynchronous external event. Active on its rising edge.
- `interrupcion`  out  1: interrupt request to the CPU, equal to `pend_tmr | pend_ext`. It is a combinational OR of flops only.
- `estado`  out  8: `{4'b0, ovr_ext, ovr_tmr, pend_ext, pend_tmr}`. To CPU port `e3`.
- `cuenta`  out  8: current timer count. To CPU port `e2`.

## Operation
**Reset.** While `reset`=0, all of the following are 0:
- the counter and prescaler;
- every pending and overrun flag;
- the synchronizer flops;
- `ctrl_q`, the registered copy of `cfg_ctrl[2:0]`.

As a result, `interrupcion`=0, `estado`=0 and `cuenta`=0. Reset may be asserted at any time, including mid-count, and takes effect immediately.

**Edge detection.** `ctrl_q` is updated every cycle.
- A rise on `en_tmr` or `ack` is `cfg_ctrl[b]=1` while `ctrl_q[b]=0`.
- Level-held `ack` has no further effect after its rise.

**Timer.**
- On the `en_tmr` rise edge: counter ← `cfg_periodo`, prescaler ← 0.
- While `en_tmr`=1 and counter≠0:
  - The prescaler counts 0..PRESC-1 and wraps.
  - A tick occurs on the edge where the prescaler equals PRESC-1.
  - On a tick with counter>1: counter decrements.
  - On a tick with counter=1, expiry occurs:
    - `pend_tmr` is set. If `pend_tmr` was already 1, `ovr_tmr` is also set.
    - Periodic mode (`one_shot`=0): counter reloads from the current `cfg_periodo`.
    - One-shot mode: counter ← 0 and counting stops until the next `en_tmr` rise.
- `cfg_periodo`=0 at load: counter stays 0 and the timer never expires.
- `en_tmr`=0: counter holds its value and the prescaler is cleared.
- A `cfg_periodo` change mid-count takes effect only at the next load or reload.

**External event.**
- `evento` passes through a 2-flop synchronizer (`s1`→`s2`) and a third flop `s3`.
- A rise is `s2 & ~s3`.
- On a rise with `en_ext`=1: `pend_ext` is set. If `pend_ext` was already 1, `ovr_ext` is also set.
- With `en_ext`=0, rises are dropped and no flag changes.

**Acknowledge.**
- The `ack` rise edge clears `pend_tmr`, `pend_ext`, `ovr_tmr` and `ovr_ext`.
- If a set condition occurs on the same edge as `ack`, set wins for that source's pending flag, and its overrun flag is cleared. No event is lost.

## Timing
- Let E0 be the edge where the `en_tmr` rise is detected.
  - Ticks occur at E0+k·PRESC for k≥1.
  - The first expiry is at E0+P·PRESC.
  - Periodic expiries follow every P·PRESC cycles.
- `interrupcion` rises in the same cycle that `pend_*` is set, with no extra register stage. It stays high until the `ack` edge.
- `evento` latency: if `evento` is high at setup for edge N, `pend_ext` is set at edge N+2 and `interrupcion` is high after that edge. Pulses shorter than one clock period may be missed.
- `cuenta` and `estado` reflect flop state after each edge, with no added latency.

## Test plan
- **Reset mid-count.** PRESC=4, periodo=5, en_tmr=1. Assert `reset`=0 after 7 cycles. Expect all outputs 0 immediately. After release, no interrupt until a new `en_tmr` rise.
- **Periodic timer.** periodo=3, `cfg_ctrl`=8'h01.
  - Expect `cuenta` 3→2→1 at E0+4 and E0+8.
  - Expect `interrupcion`=1 and `estado`=8'h01 at E0+12, with reload to 3.
  - Without ack, the next expiry at E0+24 gives `estado`=8'h05.
  - An `ack` pulse then gives `estado`=8'h00 and `interrupcion`=0.
- **One-shot.** periodo=2, `cfg_ctrl`=8'h09. Expect expiry at E0+8, then `cuenta`=0 held and no second expiry within 40 cycles. Toggle en_tmr 0→1 and expect a new expiry 8 cycles after detection.
- **External event.** `cfg_ctrl`=8'h02. Raise `evento` before edge N. Expect `estado`=8'h02 after N+2. A second rise gives 8'h0A. With en_ext=0, a rise leaves `estado` unchanged.
- **Ack collision.** Time the `ack` rise to land on the same edge as a timer expiry, with `pend_tmr` and `ovr_tmr` already set. Expect `estado`=8'h01 afterwards and `interrupcion` still 1.
- **Period change and periodo=0.** Write periodo=6 mid-count from 3. Expect the current expiry at 3 ticks, then 6-tick periods. Separately, load periodo=0 and expect no expiry in 2000 cycles.
